axil_sub_regfile: RTL and testbench

//  AXI4-Lite subordinate (responder) exposing NUM_REGS read/write registers on the axi4_if

---
 rtl/axi4l_pkg.sv | 21 ++
 rtl/axi4_if.sv | 41 ++++
 rtl/axil_sub_regfile.sv | 190 +++++++++++++++++++
 tb/tb_axil_sub_regfile.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4l_pkg.sv
// rtl/axi4l_pkg.sv - shared AXI4-Lite response codes and handshake FSM state types
package axi4l_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_WDATA,
        W_WADDR,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

endpackage

// File: rtl/axi4_if.sv
// rtl/axi4_if.sv - AXI4-Lite bundle with manager and subordinate views
interface axi4_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport manager (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport subordinate (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/axil_sub_regfile.sv
// rtl/axil_sub_regfile.sv - AXI4-Lite subordinate register file with per-register write strobes
module axil_sub_regfile
    import axi4l_pkg::*;
#(
    parameter int                      ADDR_WIDTH = 32,
    parameter int                      DATA_WIDTH = 32,
    parameter int                      NUM_REGS   = 4,
    parameter logic [DATA_WIDTH-1:0]   RESET_VAL  = '0
) (
    input  logic                           clk,
    input  logic                           rst,
    axi4_if.subordinate                    s_axi,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_stb_o
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return (a >> ADDR_LSB) < ADDR_WIDTH'(NUM_REGS);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return IDX_W'(a >> ADDR_LSB);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] byte_merge(
        input logic [DATA_WIDTH-1:0] old_d,
        input logic [DATA_WIDTH-1:0] new_d,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] m;
        m = old_d;
        for (int k = 0; k < STRB_W; k++) begin
            if (strb[k]) m[8*k +: 8] = new_d[8*k +: 8];
        end
        return m;
    endfunction

    wr_state_t             wr_state_q, wr_state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    resp_t                 bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_stb_q, wr_stb_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    rd_state_t             rd_state_q, rd_state_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    resp_t                 rresp_q, rresp_d;

    logic                  awready, wready, arready;
    logic                  commit;
    logic [ADDR_WIDTH-1:0] c_addr;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_W-1:0]     c_strb;

    // Readies come from state only; rst forces them low so nothing is accepted during reset.
    assign awready = !rst && (wr_state_q == W_IDLE || wr_state_q == W_WADDR);
    assign wready  = !rst && (wr_state_q == W_IDLE || wr_state_q == W_WDATA);
    assign arready = !rst && (rd_state_q == R_IDLE);

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_stb_d   = '0;
        regs_d     = regs_q;
        commit     = 1'b0;
        c_addr     = awaddr_q;
        c_data     = wdata_q;
        c_strb     = wstrb_q;
        case (wr_state_q)
            W_IDLE: begin
                if (s_axi.awvalid && awready && s_axi.wvalid && wready) begin
                    commit = 1'b1;
                    c_addr = s_axi.awaddr;
                    c_data = s_axi.wdata;
                    c_strb = s_axi.wstrb;
                end else if (s_axi.awvalid && awready) begin
                    awaddr_d   = s_axi.awaddr;
                    wr_state_d = W_WDATA;
                end else if (s_axi.wvalid && wready) begin
                    wdata_d    = s_axi.wdata;
                    wstrb_d    = s_axi.wstrb;
                    wr_state_d = W_WADDR;
                end
            end
            W_WDATA: begin
                if (s_axi.wvalid && wready) begin
                    commit = 1'b1;
                    c_data = s_axi.wdata;
                    c_strb = s_axi.wstrb;
                end
            end
            W_WADDR: begin
                if (s_axi.awvalid && awready) begin
                    commit = 1'b1;
                    c_addr = s_axi.awaddr;
                end
            end
            W_RESP: begin
                if (s_axi.bready) wr_state_d = W_IDLE;
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (commit) begin
            wr_state_d = W_RESP;
            if (addr_ok(c_addr)) begin
                regs_d[addr_idx(c_addr)]   = byte_merge(regs_q[addr_idx(c_addr)], c_data, c_strb);
                wr_stb_d[addr_idx(c_addr)] = 1'b1;
                bresp_d                    = RESP_OKAY;
            end else begin
                bresp_d = RESP_SLVERR;
            end
        end
    end

    // Reads sample regs_q, so a same-edge write commit is not visible to this read.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (s_axi.arvalid && arready) begin
                    rd_state_d = R_RESP;
                    if (addr_ok(s_axi.araddr)) begin
                        rdata_d = regs_q[addr_idx(s_axi.araddr)];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                end
            end
            R_RESP: begin
                if (s_axi.rready) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            wr_stb_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
            wr_stb_q   <= wr_stb_d;
            regs_q     <= regs_d;
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_o[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    end

    assign wr_stb_o      = wr_stb_q;
    assign s_axi.awready = awready;
    assign s_axi.wready  = wready;
    assign s_axi.bvalid  = (wr_state_q == W_RESP);
    assign s_axi.bresp   = bresp_q;
    assign s_axi.arready = arready;
    assign s_axi.rvalid  = (rd_state_q == R_RESP);
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = rresp_q;

endmodule

// File: tb/tb_axil_sub_regfile.sv
// tb/tb_axil_sub_regfile.sv - directed vector bench for axil_sub_regfile
module tb_axil_sub_regfile;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] regs;
    logic [3:0]   wr_stb;
    int           total = 0;
    int           bad   = 0;

    axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    axil_sub_regfile #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .NUM_REGS  (4),
        .RESET_VAL (32'h0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_axi   (bus),
        .regs_o  (regs),
        .wr_stb_o(wr_stb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [31:0]  data;
        logic [3:0]   strb;
        logic [1:0]   resp;
        logic [31:0]  rdata;
        logic [3:0]   stb;
        logic [127:0] regs;
    } vec_t;

    vec_t vecs [13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp, output logic [3:0] stb, output int lat,
                            output logic [3:0] stb_after);
        int n;
        bus.awaddr = a; bus.awvalid = 1'b1;
        bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        n = 0;
        while (!(bus.awready && bus.wready) && n < 20) begin tick(); n++; end
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        lat = 0;
        while (!bus.bvalid && lat < 20) begin tick(); lat++; end
        resp = bus.bresp;
        stb  = wr_stb;
        tick();
        stb_after = wr_stb;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                           output int lat);
        int n;
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        n = 0;
        while (!bus.arready && n < 20) begin tick(); n++; end
        tick();
        bus.arvalid = 1'b0;
        lat = 0;
        while (!bus.rvalid && lat < 20) begin tick(); lat++; end
        d    = bus.rdata;
        resp = bus.rresp;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [3:0]  stb, stb_after;
        logic [31:0] rd;
        int          lat;
        logic        stable;

        vecs[0]  = '{1'b0, 32'h0000_0008, 32'h0,          4'h0, 2'b00, 32'h0000_0000, 4'b0000, 128'h0};
        vecs[1]  = '{1'b1, 32'h0000_0004, 32'hDEADBEEF,   4'hF, 2'b00, 32'h0,         4'b0010,
                     128'h00000000_00000000_DEADBEEF_00000000};
        vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,          4'h0, 2'b00, 32'hDEADBEEF,  4'b0000,
                     128'h00000000_00000000_DEADBEEF_00000000};
        vecs[3]  = '{1'b1, 32'h0000_0000, 32'h11223344,   4'h5, 2'b00, 32'h0,         4'b0001,
                     128'h00000000_00000000_DEADBEEF_00220044};
        vecs[4]  = '{1'b0, 32'h0000_0000, 32'h0,          4'h0, 2'b00, 32'h00220044,  4'b0000,
                     128'h00000000_00000000_DEADBEEF_00220044};
        vecs[5]  = '{1'b1, 32'h0000_0010, 32'hCAFEF00D,   4'hF, 2'b10, 32'h0,         4'b0000,
                     128'h00000000_00000000_DEADBEEF_00220044};
        vecs[6]  = '{1'b0, 32'h0000_0010, 32'h0,          4'h0, 2'b10, 32'h0,         4'b0000,
                     128'h00000000_00000000_DEADBEEF_00220044};
        vecs[7]  = '{1'b1, 32'h0000_000F, 32'hAABBCCDD,   4'hF, 2'b00, 32'h0,         4'b1000,
                     128'hAABBCCDD_00000000_DEADBEEF_00220044};
        vecs[8]  = '{1'b0, 32'h0000_000E, 32'h0,          4'h0, 2'b00, 32'hAABBCCDD,  4'b0000,
                     128'hAABBCCDD_00000000_DEADBEEF_00220044};
        vecs[9]  = '{1'b1, 32'h0000_0008, 32'hFFFFFFFF,   4'h0, 2'b00, 32'h0,         4'b0100,
                     128'hAABBCCDD_00000000_DEADBEEF_00220044};
        vecs[10] = '{1'b0, 32'h0000_0008, 32'h0,          4'h0, 2'b00, 32'h0,         4'b0000,
                     128'hAABBCCDD_00000000_DEADBEEF_00220044};
        vecs[11] = '{1'b1, 32'h1000_0004, 32'h01010101,   4'hF, 2'b10, 32'h0,         4'b0000,
                     128'hAABBCCDD_00000000_DEADBEEF_00220044};
        vecs[12] = '{1'b0, 32'h8000_0000, 32'h0,          4'h0, 2'b10, 32'h0,         4'b0000,
                     128'hAABBCCDD_00000000_DEADBEEF_00220044};

        // reset with every valid raised
        rst = 1'b1;
        bus.awaddr = 32'h0; bus.awprot = 3'b0; bus.awvalid = 1'b1;
        bus.wdata = 32'h0; bus.wstrb = 4'h0; bus.wvalid = 1'b1; bus.bready = 1'b0;
        bus.araddr = 32'h0; bus.arprot = 3'b0; bus.arvalid = 1'b1; bus.rready = 1'b0;
        tick(); tick();
        check("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
        check("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        check("rst_regs", regs, 128'h0);
        check("rst_stb", wr_stb, 4'h0);
        bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
        rst = 1'b0;
        tick();
        check("idle_readies", {bus.awready, bus.wready, bus.arready}, 3'b111);

        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, stb, lat, stb_after);
                check($sformatf("v%0d_bresp", i), resp, vecs[i].resp);
                check($sformatf("v%0d_stb", i), stb, vecs[i].stb);
                check($sformatf("v%0d_stb_clear", i), stb_after, 4'h0);
                check($sformatf("v%0d_b_latency", i), lat, 0);
            end else begin
                do_read(vecs[i].addr, rd, resp, lat);
                check($sformatf("v%0d_rresp", i), resp, vecs[i].resp);
                check($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
                check($sformatf("v%0d_r_latency", i), lat, 0);
            end
            check($sformatf("v%0d_regs", i), regs, vecs[i].regs);
        end

        // W leads AW by two cycles
        bus.bready = 1'b1;
        bus.wdata = 32'h12345678; bus.wstrb = 4'h3; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        check("wfirst_ready1", {bus.awready, bus.wready}, 2'b10);
        tick();
        check("wfirst_ready2", {bus.awready, bus.wready}, 2'b10);
        check("wfirst_no_commit", regs[63:32], 32'hDEADBEEF);
        bus.awaddr = 32'h4; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("wfirst_bvalid", {bus.bvalid, bus.bresp}, 3'b100);
        check("wfirst_stb", wr_stb, 4'b0010);
        check("wfirst_reg", regs[63:32], 32'hDEAD5678);
        tick();

        // B back-pressure with a queued write behind it
        bus.bready = 1'b0;
        bus.awaddr = 32'h8; bus.awvalid = 1'b1;
        bus.wdata = 32'h00000055; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.awaddr = 32'h0; bus.wdata = 32'h0BADF00D;
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!(bus.bvalid && bus.bresp == 2'b00 && !bus.awready && !bus.wready &&
                  regs[31:0] == 32'h00220044))
                stable = 1'b0;
            tick();
        end
        check("bstall_stable", stable, 1'b1);
        check("bstall_reg2", regs[95:64], 32'h00000055);
        bus.bready = 1'b1;
        tick();
        check("queued_aw_ready", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        check("queued_commit_b", bus.bvalid, 1'b1);
        check("queued_commit_stb", wr_stb, 4'b0001);
        check("queued_commit_reg", regs[31:0], 32'h0BADF00D);
        tick();

        // R back-pressure
        bus.rready = 1'b0;
        bus.araddr = 32'h8; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (!(bus.rvalid && bus.rdata == 32'h55 && bus.rresp == 2'b00 && !bus.arready))
                stable = 1'b0;
            tick();
        end
        check("rstall_stable", stable, 1'b1);
        bus.rready = 1'b1;
        tick();
        check("rstall_release", {bus.rvalid, bus.arready}, 2'b01);

        // reset while waiting for W data, with AR and W presented during reset
        bus.awaddr = 32'h4; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("wwdata_entered", {bus.awready, bus.wready}, 2'b01);
        rst = 1'b1;
        bus.araddr = 32'h4; bus.arvalid = 1'b1;
        bus.wdata = 32'hFFFFFFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        check("midrst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        check("midrst_regs", regs, 128'h0);
        check("midrst_stb", wr_stb, 4'h0);
        check("midrst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
        rst = 1'b0;
        bus.arvalid = 1'b0; bus.wvalid = 1'b0;
        tick();
        do_write(32'hC, 32'h600DCAFE, 4'hF, resp, stb, lat, stb_after);
        check("post_rst_bresp", resp, 2'b00);
        check("post_rst_stb", stb, 4'b1000);
        check("post_rst_regs", regs, 128'h600DCAFE_00000000_00000000_00000000);
        do_read(32'hC, rd, resp, lat);
        check("post_rst_rdata", rd, 32'h600DCAFE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
